// File: rtl/gat_feat_readback.sv
// Drains the new-feature BRAM after gat_ready rises and streams it out as AXI-Stream.
// Reads are credit-limited so the output FIFO can never overflow under backpressure.
module gat_feat_readback #(
  parameter int NEW_FEATURE_WIDTH = 32,
  parameter int NUM_SUBGRAPHS     = 2708,
  parameter int NUM_FEATURE_OUT   = 16,
  parameter int RD_LATENCY        = 2,
  parameter int FIFO_DEPTH        = RD_LATENCY + 2,
  localparam int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
  localparam int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
  localparam int NODE_W             = $clog2(NUM_SUBGRAPHS) + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          gat_ready,
  input  logic                          rd_enable,
  output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
  input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
  output logic [NEW_FEATURE_WIDTH-1:0]  m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic                          m_tlast,
  output logic                          m_tuser,
  output logic                          busy,
  output logic                          done_pulse,
  output logic [NODE_W-1:0]             node_cnt,
  output logic [1:0]                    dbg_state
);

  localparam int ADDR_W = NEW_FEATURE_ADDR_W;
  localparam int FEAT_W = (NUM_FEATURE_OUT > 1) ? $clog2(NUM_FEATURE_OUT) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // Stream handshake: a word transfers on a cycle where m_tvalid and m_tready are both high;
  // once m_tvalid is raised, m_tdata/m_tlast/m_tuser hold until that transfer happens.

  state_t                  state_q, state_d;
  logic                    gat_ready_q;
  logic [ADDR_W-1:0]       word_idx_q, word_idx_d;
  logic [FEAT_W-1:0]       feat_idx_q, feat_idx_d;
  logic [ADDR_W+1:0]       last_addr_q, last_addr_d;
  logic [RD_LATENCY-1:0]   vld_q, vld_d, tlast_pipe_q, tlast_pipe_d, tuser_pipe_q, tuser_pipe_d;
  logic [CNT_W-1:0]        out_q, out_d, cnt_q, cnt_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NEW_FEATURE_WIDTH-1:0] data_mem_q [FIFO_DEPTH];
  logic [NEW_FEATURE_WIDTH-1:0] data_mem_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   last_mem_q, last_mem_d, user_mem_q, user_mem_d;
  logic [NODE_W-1:0]       node_cnt_q, node_cnt_d;

  logic             start_go, issue, ret, push, pop, credit_ok;
  logic [CNT_W:0]   inflight;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Reads in flight plus words buffered must stay below the FIFO size before issuing.
  assign inflight  = {1'b0, out_q} + {1'b0, cnt_q};
  assign credit_ok = inflight < (CNT_W + 1)'(FIFO_DEPTH);
  assign ret       = vld_q[RD_LATENCY-1];
  assign push      = ret;
  assign pop       = m_tvalid & m_tready;

  always_comb begin
    state_d  = state_q;
    start_go = 1'b0;
    issue    = 1'b0;
    case (state_q)
      IDLE: begin
        if (gat_ready && !gat_ready_q && rd_enable) begin
          start_go = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (word_idx_q == ADDR_W'(NEW_FEATURE_DEPTH - 1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_q == '0 && cnt_q == '0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    word_idx_d  = word_idx_q;
    feat_idx_d  = feat_idx_q;
    last_addr_d = last_addr_q;
    node_cnt_d  = node_cnt_q;
    if (start_go) begin
      word_idx_d  = '0;
      feat_idx_d  = '0;
      last_addr_d = '0;
      node_cnt_d  = '0;
    end else begin
      if (issue) begin
        word_idx_d  = word_idx_q + ADDR_W'(1);
        feat_idx_d  = (feat_idx_q == FEAT_W'(NUM_FEATURE_OUT - 1)) ? '0 : feat_idx_q + FEAT_W'(1);
        last_addr_d = {word_idx_q, 2'b00};
      end
      if (pop && m_tlast) node_cnt_d = node_cnt_q + NODE_W'(1);
    end
  end

  // Word tags travel alongside the read so they line up with the returning BRAM data.
  always_comb begin
    vld_d           = '0;
    tlast_pipe_d    = '0;
    tuser_pipe_d    = '0;
    vld_d[0]        = issue;
    tlast_pipe_d[0] = issue && (feat_idx_q == FEAT_W'(NUM_FEATURE_OUT - 1));
    tuser_pipe_d[0] = issue && (word_idx_q == ADDR_W'(NEW_FEATURE_DEPTH - 1));
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i]        = vld_q[i-1];
      tlast_pipe_d[i] = tlast_pipe_q[i-1];
      tuser_pipe_d[i] = tuser_pipe_q[i-1];
    end
    out_d = out_q + CNT_W'(issue) - CNT_W'(ret);
  end

  always_comb begin
    data_mem_d = data_mem_q;
    last_mem_d = last_mem_q;
    user_mem_d = user_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) begin
      data_mem_d[wr_ptr_q] = feat_bram_dout;
      last_mem_d[wr_ptr_q] = tlast_pipe_q[RD_LATENCY-1];
      user_mem_d[wr_ptr_q] = tuser_pipe_q[RD_LATENCY-1];
      wr_ptr_d             = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gat_ready_q  <= 1'b0;
      word_idx_q   <= '0;
      feat_idx_q   <= '0;
      last_addr_q  <= '0;
      vld_q        <= '0;
      tlast_pipe_q <= '0;
      tuser_pipe_q <= '0;
      out_q        <= '0;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      data_mem_q   <= '{default: '0};
      last_mem_q   <= '0;
      user_mem_q   <= '0;
      node_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      gat_ready_q  <= gat_ready;
      word_idx_q   <= word_idx_d;
      feat_idx_q   <= feat_idx_d;
      last_addr_q  <= last_addr_d;
      vld_q        <= vld_d;
      tlast_pipe_q <= tlast_pipe_d;
      tuser_pipe_q <= tuser_pipe_d;
      out_q        <= out_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      data_mem_q   <= data_mem_d;
      last_mem_q   <= last_mem_d;
      user_mem_q   <= user_mem_d;
      node_cnt_q   <= node_cnt_d;
    end
  end

  fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && cnt_q == CNT_W'(FIFO_DEPTH)));

  assign feat_bram_addrb = (state_q == IDLE) ? '0 : (issue ? {word_idx_q, 2'b00} : last_addr_q);
  assign m_tvalid   = (cnt_q != '0);
  assign m_tdata    = data_mem_q[rd_ptr_q];
  assign m_tlast    = last_mem_q[rd_ptr_q];
  assign m_tuser    = user_mem_q[rd_ptr_q];
  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign done_pulse = (state_q == DONE);
  assign node_cnt   = node_cnt_q;
  assign dbg_state  = state_q;

endmodule
